// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: types and constants used by the memory controller.
// It provides the controller FSM state type, the memory operation encodings
// and the default memory depth in 32-bit words.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request/response front end for a word-addressed
// synchronous memory. The memory returns read data one cycle after its enable.
//
// Ports
//   clock       single clock; all state changes on its rising edge
//   reset_n     synchronous active-low reset
//   req_valid   datapath request present
//   req_ready   controller can accept a request (IDLE only)
//   req_write   request operation: 0 = read, 1 = write
//   req_addr    request word address
//   req_wdata   request write data
//   rsp_valid   response held
//   rsp_ready   consumer takes the response
//   rsp_rdata   read data (0 for writes and errors)
//   rsp_err     request address was out of range
//   mem_enable  memory enable, one cycle per access
//   mem_op      memory operation: 0 = read, 1 = write
//   MAR         memory word address
//   MBR_out     memory write data
//   MBR_in      memory read data
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_enable,
  output logic        mem_op,
  output logic [31:0] MAR,
  output logic [31:0] MBR_out,
  input  logic [31:0] MBR_in
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   in_range;

  // Full 32-bit unsigned compare, so addresses far above the memory also fault.
  assign in_range  = (req_addr < MEM_WORDS);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Enable and response-valid are pure state decodes: exactly one enable cycle
  // per access, and both read 0 as soon as reset forces IDLE.
  assign mem_enable = (state == ISSUE);
  assign rsp_valid  = (state == RESP);

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = in_range ? ISSUE : RESP;
      ISSUE:   state_nxt = (mem_op == WRITE) ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_op    <= READ;
      MAR       <= '0;
      MBR_out   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // An out-of-range request never reaches the memory, so the memory-side
        // registers keep the last real access.
        if (in_range) begin
          MAR     <= req_addr;
          MBR_out <= req_wdata;
          mem_op  <= req_write;
        end
        rsp_rdata <= '0;
        rsp_err   <= !in_range;
      end
      // Read data is valid during WAIT; capture it on the edge leaving WAIT.
      if (state == WAIT) rsp_rdata <= MBR_in;
    end
  end

endmodule : mem_ctrl
